// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - EX issue stage: operand forwarding, ALU drive, two-entry skid-buffered EX/MEM register
module alu_issue_stage #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [4:0]        id_op,
  input  logic [DATA_W-1:0] id_a,
  input  logic [DATA_W-1:0] id_b,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_use_imm,
  input  logic [REG_W-1:0]  id_rs_a,
  input  logic [REG_W-1:0]  id_rs_b,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              id_wen,
  input  logic              mem_wen,
  input  logic [REG_W-1:0]  mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wb_wen,
  input  logic [REG_W-1:0]  wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic [4:0]        alu_ctrl,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_res,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [DATA_W-1:0] ex_result,
  output logic [REG_W-1:0]  ex_rd,
  output logic              ex_wen
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   head_res_q, head_res_d, skid_res_q, skid_res_d;
  logic [REG_W-1:0]    head_rd_q, head_rd_d, skid_rd_q, skid_rd_d;
  logic                head_wen_q, head_wen_d, skid_wen_q, skid_wen_d;
  logic                accept;

  // MEM is the younger producer, so it wins over WB
  always_comb begin
    alu_ctrl = id_op;
    alu_a    = id_a;
    if (mem_wen && (mem_rd == id_rs_a)) begin
      alu_a = mem_data;
    end else if (wb_wen && (wb_rd == id_rs_a)) begin
      alu_a = wb_data;
    end
    alu_b = id_b;
    if (id_use_imm) begin
      alu_b = id_imm;
    end else if (mem_wen && (mem_rd == id_rs_b)) begin
      alu_b = mem_data;
    end else if (wb_wen && (wb_rd == id_rs_b)) begin
      alu_b = wb_data;
    end
  end

  assign id_ready  = (state_q != TWO);
  assign ex_valid  = (state_q != EMPTY);
  assign ex_result = head_res_q;
  assign ex_rd     = head_rd_q;
  assign ex_wen    = head_wen_q;
  assign accept    = id_valid && id_ready;

  always_comb begin
    state_d    = state_q;
    head_res_d = head_res_q;
    head_rd_d  = head_rd_q;
    head_wen_d = head_wen_q;
    skid_res_d = skid_res_q;
    skid_rd_d  = skid_rd_q;
    skid_wen_d = skid_wen_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d    = ONE;
          head_res_d = alu_res;
          head_rd_d  = id_rd;
          head_wen_d = id_wen;
        end
      end
      ONE: begin
        if (accept && ex_ready) begin
          head_res_d = alu_res;
          head_rd_d  = id_rd;
          head_wen_d = id_wen;
        end else if (accept) begin
          state_d    = TWO;
          skid_res_d = alu_res;
          skid_rd_d  = id_rd;
          skid_wen_d = id_wen;
        end else if (ex_ready) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (ex_ready) begin
          state_d    = ONE;
          head_res_d = skid_res_q;
          head_rd_d  = skid_rd_q;
          head_wen_d = skid_wen_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Squash wins over any handshake; stale entry contents are unobservable once EMPTY
    if (flush) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= EMPTY;
      head_res_q <= '0;
      head_rd_q  <= '0;
      head_wen_q <= 1'b0;
      skid_res_q <= '0;
      skid_rd_q  <= '0;
      skid_wen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_res_q <= head_res_d;
      head_rd_q  <= head_rd_d;
      head_wen_q <= head_wen_d;
      skid_res_q <= skid_res_d;
      skid_rd_q  <= skid_rd_d;
      skid_wen_q <= skid_wen_d;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - scoreboard bench for alu_issue_stage with a behavioural ALU
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        id_valid = 1'b0, id_ready;
  logic [4:0]  id_op = '0;
  logic [15:0] id_a = '0, id_b = '0, id_imm = '0;
  logic        id_use_imm = 1'b0;
  logic [3:0]  id_rs_a = 4'd1, id_rs_b = 4'd2, id_rd = '0;
  logic        id_wen = 1'b0;
  logic        mem_wen = 1'b0, wb_wen = 1'b0;
  logic [3:0]  mem_rd = '0, wb_rd = '0;
  logic [15:0] mem_data = '0, wb_data = '0;
  logic        flush = 1'b0;
  logic [4:0]  alu_ctrl;
  logic [15:0] alu_a, alu_b, alu_res;
  logic        ex_valid, ex_ready = 1'b1;
  logic [15:0] ex_result;
  logic [3:0]  ex_rd;
  logic        ex_wen;

  typedef struct packed {
    logic [15:0] res;
    logic [3:0]  rd;
    logic        wen;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_cur;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [3:0] rd_ctr = 4'd0;

  alu_issue_stage #(.DATA_W(16), .REG_W(4)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_ready(id_ready), .id_op(id_op),
    .id_a(id_a), .id_b(id_b), .id_imm(id_imm), .id_use_imm(id_use_imm),
    .id_rs_a(id_rs_a), .id_rs_b(id_rs_b), .id_rd(id_rd), .id_wen(id_wen),
    .mem_wen(mem_wen), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_res(alu_res),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_result(ex_result), .ex_rd(ex_rd), .ex_wen(ex_wen)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] alu_model(input logic [4:0] c, input logic [15:0] a, input logic [15:0] b);
    logic [3:0] sh;
    sh = (b[3:0] == 4'd0) ? 4'd8 : b[3:0];
    case (c)
      5'd0:    return a;
      5'd1:    return b;
      5'd2:    return a + b;
      5'd3:    return a - b;
      5'd4:    return a & b;
      5'd5:    return a | b;
      5'd6:    return ~a;
      5'd7:    return a ^ b;
      5'd8:    return {15'd0, a != b};
      5'd9:    return b << a;
      5'd10:   return b >> a;
      5'd11:   return a << sh;
      5'd12:   return {15'd0, a < b};
      5'd13:   return $signed(b) >>> a;
      5'd14:   return a >> sh;
      default: return {15'd0, $signed(a) < $signed(b)};
    endcase
  endfunction

  always_comb alu_res = alu_model(alu_ctrl, alu_a, alu_b);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Stimulus side: record what the ID stage hands over
  always @(negedge clk) begin
    if (rst && id_valid && id_ready && !flush) exp_q.push_back(exp_cur);
  end

  // Checking side: compare every downstream transfer against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (rst && ex_valid && ex_ready && !flush) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL ex_out: unexpected result 0x%0h with empty scoreboard", ex_result);
      end else begin
        e = exp_q.pop_front();
        if ({ex_result, ex_rd, ex_wen} !== e) begin
          n_err++;
          $display("FAIL ex_out: got res=0x%0h rd=%0d wen=%0b expected res=0x%0h rd=%0d wen=%0b",
                   ex_result, ex_rd, ex_wen, e.res, e.rd, e.wen);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b, input logic [15:0] res);
    rd_ctr     = rd_ctr + 4'd1;
    id_valid   = 1'b1;
    id_op      = op;
    id_a       = a;
    id_b       = b;
    id_use_imm = 1'b0;
    id_rs_a    = 4'd1;
    id_rs_b    = 4'd2;
    id_rd      = rd_ctr;
    id_wen     = rd_ctr[0];
    mem_wen    = 1'b0;
    wb_wen     = 1'b0;
    exp_cur    = '{res: res, rd: rd_ctr, wen: rd_ctr[0]};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_ex_result", ex_result, 0);
    chk("rst_ex_rd_wen", {ex_rd, ex_wen}, 0);
    chk("rst_id_ready", id_ready, 1);
    rst = 1'b1;
    step();

    // basic add
    issue(5'd2, 16'h0003, 16'h0004, 16'h0007);
    step();
    id_valid = 1'b0;
    chk("add_ex_valid", ex_valid, 1);
    chk("add_ex_result", ex_result, 16'h0007);
    chk("add_id_ready", id_ready, 1);
    step();

    // forwarding priority, back-to-back at full rate
    issue(5'd0, 16'hAAAA, 16'h0000, 16'h1111);
    id_rs_a = 4'd5; mem_wen = 1'b1; mem_rd = 4'd5; mem_data = 16'h1111;
    wb_wen = 1'b1; wb_rd = 4'd5; wb_data = 16'h2222;
    step();
    chk("fwd_id_ready", id_ready, 1);
    issue(5'd0, 16'hAAAA, 16'h0000, 16'h2222);
    id_rs_a = 4'd5; wb_wen = 1'b1; wb_rd = 4'd5; wb_data = 16'h2222;
    step();
    issue(5'd1, 16'h0000, 16'hBBBB, 16'h00FF);
    id_use_imm = 1'b1; id_imm = 16'h00FF; id_rs_b = 4'd5;
    mem_wen = 1'b1; mem_rd = 4'd5; mem_data = 16'h1111;
    step();
    issue(5'd1, 16'h0000, 16'hBBBB, 16'h3333);
    id_rs_b = 4'd6; wb_wen = 1'b1; wb_rd = 4'd6; wb_data = 16'h3333;
    step();
    issue(5'd0, 16'h1234, 16'h0000, 16'h0BAD);
    id_rs_a = 4'd0; mem_wen = 1'b1; mem_rd = 4'd0; mem_data = 16'h0BAD;
    step();
    // held value must not follow later forwarding changes
    id_valid = 1'b0;
    mem_data = 16'hDEAD;
    chk("fwd_hold", ex_result, 16'h0BAD);
    step();

    // width and sign
    issue(5'd16, 16'h8000, 16'h0001, 16'h0001);
    step();
    issue(5'd11, 16'h0001, 16'h0000, 16'h0100);
    step();
    issue(5'd3, 16'h0000, 16'h0001, 16'hFFFF);
    step();
    id_valid = 1'b0;
    step();

    // backpressure: results 1..4
    issue(5'd2, 16'h0000, 16'h0001, 16'h0001);
    step();
    ex_ready = 1'b0;
    issue(5'd2, 16'h0001, 16'h0001, 16'h0002);
    step();
    chk("bp_id_ready_low", id_ready, 0);
    issue(5'd2, 16'h0001, 16'h0002, 16'h0003);
    step();
    chk("bp_head_held", ex_result, 16'h0001);
    chk("bp_still_full", {ex_valid, id_ready}, 2'b10);
    ex_ready = 1'b1;
    step();
    chk("bp_skid_to_head", ex_result, 16'h0002);
    chk("bp_id_ready_back", id_ready, 1);
    step();
    issue(5'd2, 16'h0002, 16'h0002, 16'h0004);
    step();
    id_valid = 1'b0;
    repeat (2) step();
    chk("bp_drained", ex_valid, 0);

    // flush while full with an op presented
    ex_ready = 1'b0;
    issue(5'd2, 16'h0001, 16'h0001, 16'h0002);
    step();
    issue(5'd2, 16'h0002, 16'h0002, 16'h0004);
    step();
    chk("fl2_full", id_ready, 0);
    issue(5'd2, 16'h0003, 16'h0003, 16'h0006);
    flush = 1'b1;
    chk("fl2_id_ready_during", id_ready, 0);
    step();
    flush = 1'b0;
    id_valid = 1'b0;
    chk("fl2_after", {ex_valid, id_ready}, 2'b01);
    exp_q.delete();
    ex_ready = 1'b1;
    issue(5'd4, 16'h0F0F, 16'h00FF, 16'h000F);
    step();
    id_valid = 1'b0;
    chk("fl2_next_first", ex_result, 16'h000F);
    step();

    // flush in ONE with a same-cycle accept
    ex_ready = 1'b0;
    issue(5'd5, 16'h00F0, 16'h000F, 16'h00FF);
    step();
    issue(5'd7, 16'h00FF, 16'h0F0F, 16'h0FF0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    id_valid = 1'b0;
    chk("fl1_after", {ex_valid, id_ready}, 2'b01);
    exp_q.delete();
    step();
    chk("fl1_stays_empty", ex_valid, 0);

    // async reset between edges while full
    issue(5'd2, 16'h0005, 16'h0005, 16'h000A);
    step();
    issue(5'd2, 16'h0006, 16'h0006, 16'h000C);
    step();
    id_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_ex_valid", ex_valid, 0);
    chk("arst_ex_result", ex_result, 0);
    chk("arst_id_ready", id_ready, 1);
    exp_q.delete();
    step();
    rst = 1'b1;
    ex_ready = 1'b1;
    issue(5'd6, 16'h00FF, 16'h0000, 16'hFF00);
    step();
    id_valid = 1'b0;
    step();
    step();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
